mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum wait cycles per memory transaction before abort.
REQ-002 Port clock  in  1  system clock; all state changes on rising edge.
REQ-003 Port resetN  in  1  reset: asynchronous, active-low.
REQ-004 Port mar  in  32  word address, fed from the MAR register's always-on output.
REQ-005 Port mdr  in  32  write data, fed from the MDR register's always-on output.
REQ-006 Port pc  in  32  byte address, fed from the PC register's always-on output.
REQ-007 Port rd, wr, fetch  in  1 each  single-cycle microinstruction request strobes.
REQ-008 Port memAddr  out  32  data-port byte address.
REQ-009 Port memWData  out  32  data-port write data.
REQ-010 Port memRead, memWrite  out  1 each  data-port strobes.
REQ-011 Port memReady  in  1  data-port completion.
REQ-012 Port memRData  in  32  data-port read data.
REQ-013 Port fetchAddr  out  32  fetch-port byte address.
REQ-014 Port fetchRead  out  1  fetch-port strobe.
REQ-015 Port fetchReady  in  1  fetch-port completion.
REQ-016 Port fetchRData  in  8  fetched byte.
REQ-017 Port mdrIn  out  32, mdrLoad  out  1  value and load enable driven into MDR's dataIn/inEnable.
REQ-018 Port mbrIn  out  8, mbrLoad  out  1  value and load enable driven into MBR.
REQ-019 Port dataBusy, fetchBusy  out  1 each  channel busy; dataErr, fetchErr  out  1 each  one-cycle error pulses.

Function
REQ-020 The block SHALL contain two independent channels, data and fetch, each an FSM with states IDLE and ACTIVE; the data channel's ACTIVE state is split into READ and WRITE.
REQ-021 Data IDLE: rd=1, wr=0 at edge k -> READ; wr=1, rd=0 -> WRITE; memAddr is latched as {mar[29:0],2'b00} and memWData as mdr at edge k.
REQ-022 rd=1 and wr=1 in the same IDLE cycle SHALL start no transaction and pulse dataErr for one cycle.
REQ-023 memRead SHALL be 1 exactly while in READ, memWrite exactly while in WRITE, and dataBusy while in READ or WRITE; all three SHALL be first high in the cycle after edge k.
REQ-024 memReady=1 sampled in READ SHALL return the channel to IDLE, register memRData into mdrIn, and make mdrLoad=1 for exactly the following cycle.
REQ-025 memReady=1 sampled in WRITE SHALL return the channel to IDLE with no mdrLoad.
REQ-026 Minimum latency: rd at edge k with memReady=1 at edge k+1 gives mdrLoad high in the cycle after edge k+1.
REQ-027 A 4-bit-or-wider wait counter SHALL clear on entry to READ/WRITE and increment each ACTIVE cycle without memReady.
REQ-028 When the wait counter reaches WAIT_LIMIT, the channel SHALL return to IDLE, pulse dataErr, and raise no mdrLoad.
REQ-029 rd, wr or fetch asserted while its channel is ACTIVE SHALL be dropped and SHALL pulse that channel's err.
REQ-030 memReady or fetchReady seen while its channel is IDLE SHALL be ignored.
REQ-031 Fetch channel: fetch=1 in IDLE SHALL latch fetchAddr=pc and enter ACTIVE, with fetchRead=fetchBusy=1 while ACTIVE.
REQ-032 fetchReady=1 in ACTIVE SHALL register fetchRData into mbrIn and pulse mbrLoad for one cycle; the timeout rule of REQ-027/028 SHALL apply using fetchErr.
REQ-033 The two channels SHALL operate concurrently; simultaneous rd and fetch both proceed, and mdrLoad and mbrLoad may coincide.
REQ-034 A request accepted in the same cycle its channel returns to IDLE (edge of completion) SHALL be dropped; a new request is accepted from the following edge.

Reset
REQ-035 resetN=0 SHALL immediately force both FSMs to IDLE, clear counters, and drive every output to 0 (addresses, data, strobes, loads, busy, err).
REQ-036 Reset mid-transaction SHALL abandon it; a memReady or fetchReady arriving after reset release SHALL be ignored.

Verification
REQ-037 mar=0x10, rd pulse, memReady one cycle later with memRData=0xDEADBEEF -> memAddr=0x40, memRead high one cycle, mdrIn=0xDEADBEEF, mdrLoad one cycle.
REQ-038 mar=0x3, mdr=0x12345678, wr pulse, memReady after 3 cycles -> memWrite high 3 cycles, memWData=0x12345678, no mdrLoad.
REQ-039 rd pulse, memReady never asserted -> memRead high for WAIT_LIMIT (15) cycles, then dataErr pulses once and dataBusy=0.
REQ-040 pc=0x7, fetch and rd in the same cycle, both readies after 2 cycles with fetchRData=0xA5 -> mbrIn=0xA5, mbrLoad and mdrLoad high in the same cycle.
REQ-041 rd and wr together -> dataErr pulse, memRead=memWrite=0; a second rd while READ -> dataErr pulse and the first read still completes.
REQ-042 resetN low mid-READ -> all outputs 0 asynchronously; a memReady after release -> no mdrLoad.

Source files
------------

// File: rtl/mem_ctrl.sv
// Memory controller with independent data and fetch channels.
// Each channel runs one outstanding transaction with a wait-cycle timeout.
module mem_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [31:0] mar,
  input  logic [31:0] mdr,
  input  logic [31:0] pc,
  input  logic        rd,
  input  logic        wr,
  input  logic        fetch,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  output logic        memRead,
  output logic        memWrite,
  input  logic        memReady,
  input  logic [31:0] memRData,
  output logic [31:0] fetchAddr,
  output logic        fetchRead,
  input  logic        fetchReady,
  input  logic [7:0]  fetchRData,
  output logic [31:0] mdrIn,
  output logic        mdrLoad,
  output logic [7:0]  mbrIn,
  output logic        mbrLoad,
  output logic        dataBusy,
  output logic        fetchBusy,
  output logic        dataErr,
  output logic        fetchErr
);

  localparam int CW0 = $clog2(WAIT_LIMIT + 1);
  localparam int CW = (CW0 < 4) ? 4 : CW0;
  localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {
    D_IDLE,
    D_READ,
    D_WRITE
  } dState_t;

  typedef enum logic {
    F_IDLE,
    F_ACTIVE
  } fState_t;

  dState_t       dState;
  fState_t       fState;
  logic [CW-1:0] dWait;
  logic [CW-1:0] fWait;

  // mar is a word address; its top two bits fall off the byte address
  logic unusedMarBits;
  assign unusedMarBits = ^mar[31:30];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dState   <= D_IDLE;
      dWait    <= '0;
      memAddr  <= '0;
      memWData <= '0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      dataBusy <= 1'b0;
      mdrIn    <= '0;
      mdrLoad  <= 1'b0;
      dataErr  <= 1'b0;
    end else begin
      mdrLoad <= 1'b0;
      dataErr <= 1'b0;
      unique case (dState)
        D_IDLE: begin
          if (rd && wr) begin
            dataErr <= 1'b1;
          end else if (rd || wr) begin
            dState   <= rd ? D_READ : D_WRITE;
            dWait    <= '0;
            memAddr  <= {mar[29:0], 2'b00};
            memWData <= mdr;
            memRead  <= rd;
            memWrite <= wr;
            dataBusy <= 1'b1;
          end
        end
        default: begin
          if (rd || wr) dataErr <= 1'b1;
          if (memReady) begin
            dState   <= D_IDLE;
            dWait    <= '0;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            dataBusy <= 1'b0;
            if (dState == D_READ) begin
              mdrIn   <= memRData;
              mdrLoad <= 1'b1;
            end
          end else if (dWait == LAST) begin
            dState   <= D_IDLE;
            dWait    <= '0;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            dataBusy <= 1'b0;
            dataErr  <= 1'b1;
          end else begin
            dWait <= dWait + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      fState    <= F_IDLE;
      fWait     <= '0;
      fetchAddr <= '0;
      fetchRead <= 1'b0;
      fetchBusy <= 1'b0;
      mbrIn     <= '0;
      mbrLoad   <= 1'b0;
      fetchErr  <= 1'b0;
    end else begin
      mbrLoad  <= 1'b0;
      fetchErr <= 1'b0;
      unique case (fState)
        F_IDLE: begin
          if (fetch) begin
            fState    <= F_ACTIVE;
            fWait     <= '0;
            fetchAddr <= pc;
            fetchRead <= 1'b1;
            fetchBusy <= 1'b1;
          end
        end
        default: begin
          if (fetch) fetchErr <= 1'b1;
          if (fetchReady) begin
            fState    <= F_IDLE;
            fWait     <= '0;
            fetchRead <= 1'b0;
            fetchBusy <= 1'b0;
            mbrIn     <= fetchRData;
            mbrLoad   <= 1'b1;
          end else if (fWait == LAST) begin
            fState    <= F_IDLE;
            fWait     <= '0;
            fetchRead <= 1'b0;
            fetchBusy <= 1'b0;
            fetchErr  <= 1'b1;
          end else begin
            fWait <= fWait + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
